// File: rtl/button_pkg.sv
// button_pkg: shared types and widths for the push-button front ends.
package button_pkg;

  localparam int TICK_CNT_W   = 8;  // repeat delay/rate tick counter
  localparam int STABLE_CNT_W = 4;  // debounce agreement counter

  // HOLD doubles as the single "pressed" state when auto-repeat is built out.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } btn_state_t;

endpackage

// File: rtl/debounce_tick_gen.sv
// debounce_tick_gen: divides video_clk down to a one-cycle sample tick every
// TICK_DIV cycles; shared by all button front ends.
module debounce_tick_gen #(
  parameter int TICK_DIV = 315_000
) (
  input  logic video_clk,
  input  logic reset,
  output logic tick
);
  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  // free-running 0..TICK_DIV-1 counter, wraps on the tick edge
  always_ff @(posedge video_clk) begin
    if (reset)            cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else                  cnt <= cnt + CNT_W'(1);
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/button_autorepeat.sv
// button_autorepeat: synchroniser, tick-sampled debouncer and press/repeat FSM
// feeding one-cycle increment strobes to the time/alarm counters.
// Build macro BUTTON_AUTOREPEAT_EN enables hold-to-repeat; without it every
// debounced press gives exactly one press_pulse and repeating stays 0.
module button_autorepeat
  import button_pkg::*;
#(
  parameter int TICK_DIV           = 315_000,
  parameter int DEBOUNCE_SAMPLES   = 4,
  parameter int REPEAT_DELAY_TICKS = 50,
  parameter int REPEAT_RATE_TICKS  = 15
) (
  input  logic video_clk,
  input  logic reset,
  input  logic button_in,
  output logic press_pulse,
  output logic held,
  output logic repeating
);
  localparam logic [STABLE_CNT_W-1:0] DEB_N = STABLE_CNT_W'(DEBOUNCE_SAMPLES);

  logic                    sync1, btn_sync, tick;
  logic [STABLE_CNT_W-1:0] stable_cnt;
  logic                    differ, qualify, held_rise, held_fall;
  btn_state_t              state, state_nxt;
  logic                    pulse_nxt;

  // two-flop synchroniser for the asynchronous button line
  always_ff @(posedge video_clk) begin
    if (reset) begin
      sync1    <= 1'b0;
      btn_sync <= 1'b0;
    end else begin
      sync1    <= button_in;
      btn_sync <= sync1;
    end
  end

  debounce_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .video_clk (video_clk),
    .reset     (reset),
    .tick      (tick)
  );

  // held toggles on the tick that completes DEB_N consecutive disagreeing
  // samples; the FSM sees that edge combinationally so press_pulse lines up
  // with held's first high cycle.
  assign differ    = btn_sync ^ held;
  assign qualify   = tick && differ && ((stable_cnt + STABLE_CNT_W'(1)) == DEB_N);
  assign held_rise = qualify && !held;
  assign held_fall = qualify &&  held;

  // debouncer: count disagreeing tick samples, clear on any agreeing one
  always_ff @(posedge video_clk) begin
    if (reset) begin
      stable_cnt <= '0;
      held       <= 1'b0;
    end else if (tick) begin
      if (!differ) begin
        stable_cnt <= '0;
      end else if (qualify) begin
        stable_cnt <= '0;
        held       <= ~held;
      end else begin
        stable_cnt <= stable_cnt + STABLE_CNT_W'(1);
      end
    end
  end

`ifdef BUTTON_AUTOREPEAT_EN
  localparam logic [TICK_CNT_W:0] DELAY_N = (TICK_CNT_W+1)'(REPEAT_DELAY_TICKS);
  localparam logic [TICK_CNT_W:0] RATE_N  = (TICK_CNT_W+1)'(REPEAT_RATE_TICKS);

  logic [TICK_CNT_W-1:0] tick_cnt, tick_cnt_nxt, tick_cnt_sat;
  logic [TICK_CNT_W:0]   tick_cnt_p1;

  // compare on a one-bit-wider sum so a full counter can never alias
  assign tick_cnt_p1  = {1'b0, tick_cnt} + (TICK_CNT_W+1)'(1);
  assign tick_cnt_sat = (&tick_cnt) ? tick_cnt : tick_cnt_p1[TICK_CNT_W-1:0];

  // next-state: press pulse, delay to first repeat, then fixed-rate repeats;
  // a release always wins over a repeat due on the same tick
  always_comb begin
    state_nxt    = state;
    tick_cnt_nxt = tick_cnt;
    pulse_nxt    = 1'b0;
    case (state)
      IDLE: begin
        tick_cnt_nxt = '0;
        if (held_rise) begin
          pulse_nxt = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (held_fall) begin
          state_nxt    = IDLE;
          tick_cnt_nxt = '0;
        end else if (tick) begin
          if (tick_cnt_p1 == DELAY_N) begin
            pulse_nxt    = 1'b1;
            tick_cnt_nxt = '0;
            state_nxt    = REPEAT;
          end else begin
            tick_cnt_nxt = tick_cnt_sat;
          end
        end
      end
      REPEAT: begin
        if (held_fall) begin
          state_nxt    = IDLE;
          tick_cnt_nxt = '0;
        end else if (tick) begin
          if (tick_cnt_p1 == RATE_N) begin
            pulse_nxt    = 1'b1;
            tick_cnt_nxt = '0;
          end else begin
            tick_cnt_nxt = tick_cnt_sat;
          end
        end
      end
      default: begin
        state_nxt    = IDLE;
        tick_cnt_nxt = '0;
      end
    endcase
  end

  // FSM state, tick counter and registered strobe
  always_ff @(posedge video_clk) begin
    if (reset) begin
      state       <= IDLE;
      tick_cnt    <= '0;
      press_pulse <= 1'b0;
    end else begin
      state       <= state_nxt;
      tick_cnt    <= tick_cnt_nxt;
      press_pulse <= pulse_nxt;
    end
  end

  assign repeating = (state == REPEAT);
`else
  // repeat timing is not built; keep the parameters referenced
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = REPEAT_DELAY_TICKS[0] ^ REPEAT_RATE_TICKS[0];

  // next-state: one pulse on press, then wait in HOLD for the release
  always_comb begin
    state_nxt = state;
    pulse_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (held_rise) begin
          pulse_nxt = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (held_fall) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state and registered strobe
  always_ff @(posedge video_clk) begin
    if (reset) begin
      state       <= IDLE;
      press_pulse <= 1'b0;
    end else begin
      state       <= state_nxt;
      press_pulse <= pulse_nxt;
    end
  end

  assign repeating = 1'b0;
`endif

endmodule
